// File: rtl/adc_spi_capture.sv
`default_nettype none
// ============================================================================
//  Module   : adc_spi_capture
//  Purpose  : SPI capture engine for NCH serial ADCs sharing CS and SCLK.
//             Runs entirely on clk and generates cs_n/sclk itself. Supports
//             single-shot (start) and back-to-back (continuous) frames, a
//             read handshake (data_valid/data_ack) and sticky overrun.
//  Ports    : clk, reset_n (async, active low)
//             start, continuous     - frame requests (sampled in IDLE)
//             sdata[NCH]            - serial data, bit c = channel c
//             data_ack              - consumer has read data_out
//             cs_n, sclk            - ADC pins (both idle high)
//             data_out              - channel c at [c*DATA_BITS +: DATA_BITS]
//             done_tick, data_valid, overrun, busy, frame_err
//  Options  : ADC_FRAME_CHECK_EN - when defined, the leading (non-data) bits
//             of every frame are checked for zero; a violation sets the
//             sticky frame_err. Undefined: frame_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_spi_capture #(
    parameter int NCH          = 2,
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [NCH-1:0]           sdata,
    input  logic                     data_ack,
    output logic                     cs_n,
    output logic                     sclk,
    output logic [NCH*DATA_BITS-1:0] data_out,
    output logic                     done_tick,
    output logic                     data_valid,
    output logic                     overrun,
    output logic                     busy,
    output logic                     frame_err
);

    localparam int c_CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_QUIET_LAST = c_CNT_W'(QUIET_CYCLES - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(FRAME_BITS - 1);

    // Without the leading-bit check only the data bits need storing: the
    // leading bits simply fall off the top of the shift register.
`ifdef ADC_FRAME_CHECK_EN
    localparam int c_SR_W = FRAME_BITS;
`else
    localparam int c_SR_W = DATA_BITS;
`endif

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_LOAD  = 3'd3;
    localparam logic [2:0] c_QUIET = 3'd4;

    logic [2:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [c_BIT_W-1:0] r_bit, w_bit_nxt;
    logic               r_phase, w_phase_nxt;   // 0: sclk low half, 1: sclk high half
    logic               w_sample;
    logic               w_cs_n_nxt, w_sclk_nxt, w_busy_nxt;
    logic               r_cs_n, r_sclk, r_busy;
    logic [c_SR_W-1:0]  r_shift [NCH];
    logic [NCH*DATA_BITS-1:0] r_data_out;
    logic               r_done, r_valid, r_overrun;

    // ------------------------------------------------------------------
    // State register (with the timing counters that belong to the FSM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_phase_nxt = r_phase;
        w_sample    = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                if (start || continuous) begin
                    w_state_nxt = c_SETUP;
                end
            end
            c_SETUP: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_state_nxt = c_SHIFT;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            c_SHIFT: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_phase) begin
                        // End of the low half: this edge raises sclk and samples.
                        w_sample = 1'b1;
                        if (r_bit == c_BIT_LAST) begin
                            w_state_nxt = c_LOAD;
                        end else begin
                            w_phase_nxt = 1'b1;
                            w_bit_nxt   = r_bit + 1'b1;
                        end
                    end else begin
                        w_phase_nxt = 1'b0;
                    end
                end
            end
            c_LOAD: begin
                w_state_nxt = c_QUIET;
                w_cnt_nxt   = '0;
            end
            c_QUIET: begin
                if (r_cnt == c_QUIET_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = continuous ? c_SETUP : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state; registered below so the ADC pins
    // are glitch-free and change on the same edge as the state.
    // LOAD is the single cycle after the last sample: the frame is committed
    // on the edge that leaves it, which is also where cs_n rises.
    // ------------------------------------------------------------------
    always_comb begin
        w_cs_n_nxt = 1'b1;
        w_sclk_nxt = 1'b1;
        w_busy_nxt = (w_state_nxt != c_IDLE);
        if (w_state_nxt == c_SETUP || w_state_nxt == c_SHIFT || w_state_nxt == c_LOAD) begin
            w_cs_n_nxt = 1'b0;
        end
        if (w_state_nxt == c_SHIFT && !w_phase_nxt) begin
            w_sclk_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pin registers and capture datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_data_out <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_shift[c] <= '0;
            end
        end else begin
            r_cs_n <= w_cs_n_nxt;
            r_sclk <= w_sclk_nxt;
            r_busy <= w_busy_nxt;
            r_done <= (r_state == c_LOAD);
            if (w_sample) begin
                for (int c = 0; c < NCH; c++) begin
                    r_shift[c] <= {r_shift[c][c_SR_W-2:0], sdata[c]};
                end
            end
            if (r_state == c_LOAD) begin
                for (int c = 0; c < NCH; c++) begin
                    r_data_out[c*DATA_BITS +: DATA_BITS] <= r_shift[c][DATA_BITS-1:0];
                end
                // An ack in the LOAD cycle retires the old word, so the new
                // one is valid with no overrun.
                r_valid <= 1'b1;
                if (r_valid && !data_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (data_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef ADC_FRAME_CHECK_EN
    localparam logic [c_SR_W-1:0] c_LEAD_MASK = {c_SR_W{1'b1}} << DATA_BITS;
    logic w_lead_err;
    logic r_frame_err;

    always_comb begin
        w_lead_err = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            w_lead_err = w_lead_err | (|(r_shift[c] & c_LEAD_MASK));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
        end else if (r_state == c_LOAD && w_lead_err) begin
            r_frame_err <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    assign cs_n       = r_cs_n;
    assign sclk       = r_sclk;
    assign busy       = r_busy;
    assign done_tick  = r_done;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;
    assign data_out   = r_data_out;

endmodule
`default_nettype wire
